// File: rtl/conv_layer_sequencer.sv
// Row-by-row sequencer for a 5x5-filter / 7x7-ifmap convolution layer: memory, PE array, adder.
// Optional build macro WATCHDOG_EN adds a per-state timeout that traps the FSM in ERR.
module conv_layer_sequencer #(
    parameter int NUM_PE      = 5,
    parameter int OUT_ROWS    = 3,
    parameter int WDOG_CYCLES = 1024
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start_req,
    output logic                        start_ack,
    output logic                        mem_go,
    input  logic                        mem_done,
    output logic [NUM_PE-1:0]           pe_go,
    input  logic [NUM_PE-1:0]           pe_done,
    output logic                        add_go,
    input  logic                        add_done,
    output logic [$clog2(OUT_ROWS):0]   row_idx,
    output logic                        busy,
    output logic                        done_req,
    input  logic                        done_ack,
    output logic                        err
);
    localparam int RW = $clog2(OUT_ROWS) + 1;
    localparam logic [RW-1:0] LAST_ROW = RW'(OUT_ROWS - 1);

    typedef enum logic [2:0] {IDLE, LOAD, COMPUTE, ACCUM, DONE, ERR} state_t;

    state_t            state, next_state;
    logic              first;  // high only in the first cycle spent in a state
    logic [NUM_PE-1:0] mask, mask_next;
    logic [RW-1:0]     row_next;
    logic              wdog_trip;

    // NOTE: all state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            first   <= 1'b0;
            mask    <= '0;
            row_idx <= '0;
        end else begin
            state   <= next_state;
            first   <= (next_state != state);
            mask    <= mask_next;
            row_idx <= row_next;
        end
    end

`ifdef WATCHDOG_EN
    localparam int CW = $clog2(WDOG_CYCLES + 1);
    logic [CW-1:0] wdog_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            wdog_cnt <= '0;
        else if (next_state != state)
            wdog_cnt <= '0;
        else if (state == LOAD || state == COMPUTE || state == ACCUM)
            wdog_cnt <= wdog_cnt + 1'b1;
    end

    // Trips on the cycle whose increment would make the count reach WDOG_CYCLES.
    assign wdog_trip = (state == LOAD || state == COMPUTE || state == ACCUM) &&
                       (wdog_cnt == CW'(WDOG_CYCLES - 1));
    assign err = (state == ERR);
`else
    logic unused_wdog;
    assign unused_wdog = ^WDOG_CYCLES;
    assign wdog_trip   = 1'b0;
    assign err         = 1'b0;
`endif

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        next_state = state;
        mask_next  = mask;
        row_next   = row_idx;
        start_ack  = 1'b0;
        mem_go     = 1'b0;
        pe_go      = '0;
        add_go     = 1'b0;

        case (state)
            IDLE: begin
                // Gated by rst_n so the ack stays low while reset is held.
                if (start_req && rst_n) begin
                    start_ack  = 1'b1;
                    row_next   = '0;
                    next_state = LOAD;
                end
            end
            LOAD: begin
                if (first)
                    mem_go = 1'b1;
                else if (mem_done)
                    next_state = COMPUTE;
            end
            COMPUTE: begin
                if (first) begin
                    pe_go     = '1;
                    mask_next = '0;
                end else begin
                    mask_next = mask | pe_done;
                    if (&mask_next)
                        next_state = ACCUM;
                end
            end
            ACCUM: begin
                if (first) begin
                    add_go = 1'b1;
                end else if (add_done) begin
                    if (row_idx == LAST_ROW) begin
                        next_state = DONE;
                    end else begin
                        row_next   = row_idx + 1'b1;
                        next_state = LOAD;
                    end
                end
            end
            DONE: begin
                if (done_ack) begin
                    row_next   = '0;
                    next_state = IDLE;
                end
            end
            ERR: ;
            default: next_state = IDLE;
        endcase

        if (wdog_trip) begin
            next_state = ERR;
            row_next   = row_idx;
        end
    end

    assign busy     = (state != IDLE);
    assign done_req = (state == DONE);

endmodule

// File: doc/conv_layer_sequencer.md
Name: conv_layer_sequencer

Overview:
Clocked sequencer for one 5x5-filter / 7x7-ifmap convolution layer. Accepts a start request, then for each output row it issues one-cycle go pulses to memory, then all PEs in parallel, then the adder, and collects the matching done pulses. After the last output row it raises a done request, held until acknowledged. It sits between the testbench/host and the PE array, adder and memory.

Parameters:
NUM_PE, 5, number of PEs started and collected per row
OUT_ROWS, 3, output rows per layer (7-5+1)
WDOG_CYCLES, 1024, wait-state timeout in cycles (used only with WATCHDOG_EN)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start_req  in  1  layer start request (level)
start_ack  out  1  one-cycle pulse: request accepted
mem_go  out  1  one-cycle pulse: memory loads row operands
mem_done  in  1  one-cycle pulse from memory
pe_go  out  NUM_PE  one-cycle pulse to every PE, all bits together
pe_done  in  NUM_PE  per-PE one-cycle done pulses, arbitrary order and timing
add_go  out  1  one-cycle pulse: adder accumulates PE partial sums
add_done  in  1  one-cycle pulse from adder
row_idx  out  $clog2(OUT_ROWS)+1  current output row, 0-based
busy  out  1  high in every state except IDLE
done_req  out  1  layer complete, held until done_ack
done_ack  in  1  host acknowledge of done_req
err  out  1  watchdog error flag

Behaviour:
- Async reset (rst_n=0): state=IDLE; all outputs 0; row_idx=0; PE done mask cleared. Reset mid-operation aborts immediately with no cleanup pulses.
- States: IDLE, LOAD, COMPUTE, ACCUM, DONE, ERR.
- IDLE: if start_req=1 then start_ack=1 for that cycle, row_idx<=0, next=LOAD. While busy, start_req is ignored and start_ack stays 0.
- LOAD: mem_go=1 only in the first cycle of entry. Waits for mem_done, then next=COMPUTE.
- COMPUTE: pe_go=all-ones in the first cycle of entry; the done mask clears in the same cycle. Each pe_done bit sets a sticky mask bit. Multiple bits may arrive in one cycle. Repeat pulses on an already-set bit are harmless. When the mask is all ones, including in the cycle the final bits arrive, next=ACCUM.
- ACCUM: add_go=1 in the first cycle of entry. Waits for add_done.
  - On add_done with row_idx==OUT_ROWS-1: next=DONE.
  - Otherwise: row_idx<=row_idx+1 and next=LOAD.
- DONE: done_req=1, held. When done_ack=1: done_req<=0, row_idx<=0, next=IDLE. done_ack while not in DONE is ignored.
- Done pulses arriving in any state other than the matching wait state are ignored, including the go cycle itself for mem/add. PE bits are captured only from the cycle after pe_go.
- Minimum latency: start_ack to first mem_go is 1 cycle. Each go to next-stage go is done latency + 1 cycle.
- Go pulses never overlap. Exactly one of mem_go, pe_go, add_go may be nonzero in any cycle.
- busy=1 in LOAD, COMPUTE, ACCUM, DONE and ERR.

Optional Feature:
Macro WATCHDOG_EN.
- Defined: a cycle counter resets on every state entry and increments in LOAD, COMPUTE and ACCUM. When it reaches WDOG_CYCLES, next=ERR. In ERR: err=1, busy=1, all go outputs 0, and only rst_n exits.
- Not defined: no counter; err tied 0; ERR is unreachable; waits are unbounded.

Test Plan:
1. Reset, then start_req=1 with each unit replying done 3 cycles after its go -> start_ack pulse; mem/pe/add go sequence repeated 3 times with row_idx 0,1,2; done_req rises after the third add_done; done_ack returns to IDLE with busy=0.
2. pe_done bits arrive in order 4,0,2 together with 3, then 1 ten cycles later -> add_go asserts exactly 1 cycle after bit 1 arrives, not before.
3. Stray mem_done/add_done/pe_done pulses in IDLE and DONE, and pe_done[2] pulsed twice in COMPUTE -> no state change and no extra go pulses; sequence completes normally.
4. start_req held high through the whole layer -> a single start_ack. After done_ack a new start_ack follows on the next IDLE cycle.
5. rst_n pulsed low mid-COMPUTE on row 1 -> all outputs 0 asynchronously; after release, a new start restarts at row_idx=0.
6. With WATCHDOG_EN and WDOG_CYCLES=16, withhold add_done -> err=1 16 cycles after add_go and no further go pulses. Without the macro -> err stays 0 indefinitely.
